// File: rtl/bin_to_bcd_2digit_if.sv
// Binary-in / two-BCD-digits-out bundle between the clock counters and the display path.
// The master drives the binary count; the slave returns the registered tens and units digits.
interface bin_to_bcd_2digit_if #(
    parameter int BIN_W = 6
);
    logic [BIN_W-1:0] bin;
    logic [3:0]       left_digit;
    logic [3:0]       right_digit;

    modport master (
        output bin,
        input  left_digit,
        input  right_digit
    );

    modport slave (
        input  bin,
        output left_digit,
        output right_digit
    );
endinterface

// File: rtl/bin_to_bcd_2digit.sv
// Binary count to two BCD digits (tens/units) via shift-add-3, registered once on clk.
// Latency 1 clock, no backpressure: bin is sampled every edge; outputs come straight from flops.
module bin_to_bcd_2digit #(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    bin_to_bcd_2digit_if.slave     bcd_if
);
    localparam int WORK_W = BIN_W + 4 * DIGITS;

    generate
        if (DIGITS != 2 || ((2 ** BIN_W) - 1) > 99) begin : g_bad_param
            $error("bin_to_bcd_2digit: BIN_W must fit in two decimal digits and DIGITS must be 2");
        end
    endgenerate

    logic [WORK_W-1:0] work;
    logic [3:0]        left_d;
    logic [3:0]        right_d;
    logic [3:0]        left_q;
    logic [3:0]        right_q;

    // Double dabble: the binary value sits in the low BIN_W bits and is shifted up
    // into the BCD field; any digit >= 5 is bumped by 3 before each shift.
    always_comb begin
        work = '0;
        work[BIN_W-1:0] = bcd_if.bin;
        for (int i = 0; i < BIN_W; i++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (work[BIN_W + 4*d +: 4] >= 4'd5) begin
                    work[BIN_W + 4*d +: 4] = work[BIN_W + 4*d +: 4] + 4'd3;
                end
            end
            work = work << 1;
        end
        right_d = work[BIN_W +: 4];
        left_d  = work[BIN_W + 4 +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_q  <= 4'd0;
            right_q <= 4'd0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign bcd_if.left_digit  = left_q;
    assign bcd_if.right_digit = right_q;
endmodule

// File: tb/tb_bin_to_bcd_2digit.sv
// Directed bench for bin_to_bcd_2digit: reset, basic values, digit boundaries, full sweep,
// mid-stream reset and glitching input between edges.
module tb_bin_to_bcd_2digit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bin_to_bcd_2digit_if #(.BIN_W(6)) bcd_if ();

    bin_to_bcd_2digit #(
        .BIN_W  (6),
        .DIGITS (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bcd_if (bcd_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Values are packed {tens, units}, so a hand-written 8'hTU reads as the decimal pair.
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d/%0d expected %0d/%0d", tag, got[7:4], got[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bcd_if.left_digit, bcd_if.right_digit};
    endfunction

    function automatic logic [7:0] ref_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // Drive at the falling edge, then sample 1 ns after the following rising edge.
    task automatic apply(input logic [5:0] v, input logic r);
        @(negedge clk);
        bcd_if.bin = v;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] basic_in  [5] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd25};
    logic [7:0] basic_exp [5] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h25};
    logic [5:0] bound_in  [7] = '{6'd9, 6'd10, 6'd19, 6'd20, 6'd59, 6'd60, 6'd63};
    logic [7:0] bound_exp [7] = '{8'h09, 8'h10, 8'h19, 8'h20, 8'h59, 8'h60, 8'h63};

    initial begin
        logic [7:0] prev;
        rst        = 1'b1;
        bcd_if.bin = 6'd37;

        apply(6'd37, 1'b1);
        check("reset_cyc1", outs(), 8'h00);
        apply(6'd37, 1'b1);
        check("reset_cyc2", outs(), 8'h00);
        apply(6'd37, 1'b0);
        check("after_reset_37", outs(), 8'h37);

        // Basic values, also confirming the old result holds until the edge.
        prev = 8'h37;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bcd_if.bin = basic_in[i];
            rst        = 1'b0;
            #1;
            check("basic_hold", outs(), prev);
            @(posedge clk);
            #1;
            check($sformatf("basic_%0d", basic_in[i]), outs(), basic_exp[i]);
            prev = basic_exp[i];
        end

        for (int i = 0; i < 7; i++) begin
            apply(bound_in[i], 1'b0);
            check($sformatf("bound_%0d", bound_in[i]), outs(), bound_exp[i]);
        end

        // Full sweep with a one-cycle reset pulse landing on 47.
        for (int v = 0; v < 64; v++) begin
            if (v == 47) begin
                apply(6'(v), 1'b1);
                check("midreset_47", outs(), 8'h00);
            end else begin
                apply(6'(v), 1'b0);
                check($sformatf("sweep_%0d", v), outs(), ref_bcd(v));
            end
            check("range_left", {7'd0, bcd_if.left_digit <= 4'd9}, 8'd1);
            check("range_right", {7'd0, bcd_if.right_digit <= 4'd9}, 8'd1);
        end

        // Several input changes between two edges: only the last one counts.
        @(negedge clk);
        bcd_if.bin = 6'd12;
        #1 bcd_if.bin = 6'd45;
        #1 bcd_if.bin = 6'd33;
        #1;
        check("glitch_hold", outs(), 8'h63);
        @(posedge clk);
        #1;
        check("glitch_33", outs(), 8'h33);

        // An unknown input cycle must clear on the next valid value.
        apply(6'bxxxxxx, 1'b0);
        apply(6'd17, 1'b0);
        check("x_recover_17", outs(), 8'h17);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_2digit.md
Name: bin_to_bcd_2digit

Overview:
- Converts an unsigned binary count (seconds/minutes/hours value in the real-time clock) into two BCD digits for the 7-segment display path.
- Conversion is combinational (shift-add-3 / double-dabble or equivalent divide-by-10).
- Result is registered once on the system clock, so digit outputs are glitch-free and aligned to the clock domain.
- Sits between the clock counters and the segment decoder/multiplexer.

Parameters:
- BIN_W, 6, width of the binary input. Must satisfy 2^BIN_W - 1 <= 99.
- DIGITS, 2, number of BCD digits produced. Fixed at 2 for this block; any other value is illegal.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- bin  input  BIN_W (6)  unsigned binary value, 0..63
- left_digit  output  4  BCD tens digit (most significant)
- right_digit  output  4  BCD units digit (least significant)

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, left_digit=4'd0 and right_digit=4'd0. Reset has priority over the conversion update.
- Normal operation: on every rising clk edge with rst=0:
  - left_digit <= bin / 10
  - right_digit <= bin % 10
  - bin is sampled every cycle; there is no enable and no handshake.
- Latency: exactly 1 clock. The value of bin at edge N appears on the outputs after edge N and holds until edge N+1.
- Output range:
  - right_digit is always 0..9.
  - left_digit is always 0..6 for 6-bit input. Codes 10..15 never appear on either output.
- Full input range 0..63 converts exactly. There is no saturation at 59; clamping for time values is the counters' job.
- Input change between edges: only the value present at the rising edge matters. Combinational glitches on bin must not reach the outputs.
- Reset asserted mid-operation: outputs go to 0 on that edge. The first conversion after deassertion uses bin sampled at the first edge with rst=0.
- Outputs are driven only by flops; no combinational path from bin to the outputs.
- No latches. Any X on bin propagates only to the outputs of that cycle and clears on the next valid input.
- Width rule: the internal shift-add-3 uses BIN_W + 4*DIGITS bits of working storage; no truncation before the final result.

Test Plan:
- Reset: hold rst=1 for 2 cycles with bin=6'd37 -> left_digit=0 and right_digit=0 on both cycles. Release rst -> next edge gives left=3, right=7.
- Basic values, applied in sequence one per clock:
  - bin=0 -> 0/0
  - bin=1 -> 0/1
  - bin=2 -> 0/2
  - bin=4 -> 0/4
  - bin=25 (6'b011001) -> 2/5
  - Each result appears exactly one cycle after its input is applied.
- Digit boundaries:
  - bin=9 -> 0/9
  - bin=10 -> 1/0
  - bin=19 -> 1/9
  - bin=20 -> 2/0
  - bin=59 -> 5/9
  - bin=60 -> 6/0
  - bin=63 -> 6/3
- Exhaustive sweep: bin=0..63, one value per clock. Check each output pair against (v/10, v%10) one cycle later, and check both digits are always <=9.
- Latency/glitch check: change bin several times between two clock edges (e.g. 12 -> 45 -> 33). Outputs must stay constant until the edge, then show only 3/3.
- Mid-stream reset: while sweeping, assert rst for one cycle at bin=47 -> outputs 0/0 that cycle. Next cycle with bin=48 and rst=0 -> outputs 4/8.
